// File: rtl/interfaz_alu_uart.sv
// Sequencing controller between the UART RX/TX byte interfaces and a combinational ALU.
// Define OP_CHECK_EN to reject opcode bytes the ALU does not implement.
module interfaz_alu_uart #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_done,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [NB_DATA-1:0] tx_data,
  output logic [NB_DATA-1:0] alu_A,
  output logic [NB_DATA-1:0] alu_B,
  output logic [NB_OP-1:0]   alu_Op,
  input  logic [NB_DATA-1:0] alu_R,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_CALC    = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d;
  logic [NB_DATA-1:0] alu_b_q, alu_b_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

`ifdef OP_CHECK_EN
  // Opcodes implemented by the downstream ALU.
  function automatic logic op_valid(input logic [NB_OP-1:0] op);
    logic ok;
    case (op)
      NB_OP'(6'b100000): ok = 1'b1;
      NB_OP'(6'b100010): ok = 1'b1;
      NB_OP'(6'b100100): ok = 1'b1;
      NB_OP'(6'b100101): ok = 1'b1;
      NB_OP'(6'b100110): ok = 1'b1;
      NB_OP'(6'b000011): ok = 1'b1;
      NB_OP'(6'b000010): ok = 1'b1;
      NB_OP'(6'b100111): ok = 1'b1;
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  // Next-state and datapath capture logic.
  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tx_data_d = tx_data_q;

    case (state_q)
      S_WAIT_A: begin
        if (rx_done) begin
          alu_a_d = rx_data;
          state_d = S_WAIT_B;
        end else begin
          state_d = S_WAIT_A;
        end
      end
      S_WAIT_B: begin
        if (rx_done) begin
          alu_b_d = rx_data;
          state_d = S_WAIT_OP;
        end else begin
          state_d = S_WAIT_B;
        end
      end
      S_WAIT_OP: begin
`ifdef OP_CHECK_EN
        if (rx_done && op_valid(rx_data[NB_OP-1:0])) begin
`else
        if (rx_done) begin
`endif
          alu_op_d = rx_data[NB_OP-1:0];
          state_d  = S_CALC;
        end else begin
          state_d = S_WAIT_OP;
        end
      end
      S_CALC: begin
        // Operands have been stable on the ALU for a full cycle here.
        tx_data_d = alu_R;
        state_d   = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_done) begin
          state_d = S_WAIT_A;
        end else begin
          state_d = S_WAIT_TX;
        end
      end
      default: begin
        state_d = S_WAIT_A;
      end
    endcase
  end

  // Moore outputs derived from the next state so they register alongside it.
  always_comb begin
    tx_start_d = 1'b0;
    busy_d     = 1'b0;
    case (state_d)
      S_CALC: begin
        busy_d = 1'b1;
      end
      S_SEND: begin
        busy_d     = 1'b1;
        tx_start_d = 1'b1;
      end
      S_WAIT_TX: begin
        busy_d = 1'b1;
      end
      default: begin
        busy_d     = 1'b0;
        tx_start_d = 1'b0;
      end
    endcase
  end

  // Sticky overrun: a byte arrived while a result was being computed or sent.
  always_comb begin
    if (rx_done && busy_q) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WAIT_A;
      alu_a_q    <= {NB_DATA{1'b0}};
      alu_b_q    <= {NB_DATA{1'b0}};
      alu_op_q   <= {NB_OP{1'b0}};
      tx_data_q  <= {NB_DATA{1'b0}};
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign alu_A    = alu_a_q;
  assign alu_B    = alu_b_q;
  assign alu_Op   = alu_op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_interfaz_alu_uart.sv
// Directed bench for interfaz_alu_uart with a behavioural ALU on alu_R.
module tb_interfaz_alu_uart;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_r;
  logic       busy;
  logic       overrun;

  int n_cmp = 0;
  int n_fail = 0;

  interfaz_alu_uart #(.NB_DATA(8), .NB_OP(6)) dut (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
    .alu_A(alu_a), .alu_B(alu_b), .alu_Op(alu_op), .alu_R(alu_r),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      6'b100000: alu_r = alu_a + alu_b;
      6'b100010: alu_r = alu_a - alu_b;
      6'b100100: alu_r = alu_a & alu_b;
      6'b100101: alu_r = alu_a | alu_b;
      6'b100110: alu_r = alu_a ^ alu_b;
      6'b000011: alu_r = $unsigned($signed(alu_a) >>> alu_b);
      6'b000010: alu_r = alu_a >> alu_b;
      6'b100111: alu_r = ~(alu_a | alu_b);
      default:   alu_r = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic check_result(input string tag, input logic [7:0] exp);
    check({tag, "_calc_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_calc_nostart"}, {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    check({tag, "_start"}, {31'd0, tx_start}, 32'd1);
    check({tag, "_txdata"}, {24'd0, tx_data}, {24'd0, exp});
    @(negedge clk);
    check({tag, "_start_end"}, {31'd0, tx_start}, 32'd0);
    check({tag, "_waittx_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  initial begin
    int starts;
    // Reset state
    @(negedge clk);
    check("rst_txdata", {24'd0, tx_data}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 1: 5 + 3
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    check("f1_a", {24'd0, alu_a}, 32'h05);
    check("f1_b", {24'd0, alu_b}, 32'h03);
    check("f1_op", {26'd0, alu_op}, 32'h20);
    check_result("f1", 8'h08);
    pulse_tx_done();
    check("f1_idle", {31'd0, busy}, 32'd0);
    check("f1_ovr", {31'd0, overrun}, 32'd0);

    // Frame 2: 3 - 5, transmitter slow
    send_byte(8'h03);
    send_byte(8'h05);
    send_byte(8'h22);
    check_result("f2", 8'hFE);
    starts = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    check("f2_hold_busy", {31'd0, busy}, 32'd1);
    check("f2_no_restart", starts, 32'd0);

    // Byte during WAIT_TX is dropped and flagged
    send_byte(8'h77);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_a_kept", {24'd0, alu_a}, 32'h03);
    pulse_tx_done();
    check("f2_idle", {31'd0, busy}, 32'd0);

    // Frame 3: 0x0F | 0xF0
    send_byte(8'h0F);
    send_byte(8'hF0);
    send_byte(8'h25);
    check_result("f3", 8'hFF);
    pulse_tx_done();
    check("f3_ovr_sticky", {31'd0, overrun}, 32'd1);

    // Unimplemented opcode 0x3F
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h3F);
`ifdef OP_CHECK_EN
    check("inv_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("inv_nostart", {31'd0, tx_start}, 32'd0);
    check("inv_op_kept", {26'd0, alu_op}, 32'h25);
    send_byte(8'h26);
    check_result("xor", 8'h03);
`else
    check("inv_op", {26'd0, alu_op}, 32'h3F);
    check_result("inv", 8'h00);
`endif
    pulse_tx_done();

    // Reset in the middle of a frame
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    check("mrst_a", {24'd0, alu_a}, 32'h0);
    check("mrst_b", {24'd0, alu_b}, 32'h0);
    check("mrst_op", {26'd0, alu_op}, 32'h0);
    check("mrst_tx", {24'd0, tx_data}, 32'h0);
    check("mrst_ovr", {31'd0, overrun}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h80);
    send_byte(8'h01);
    send_byte(8'h03);
    check_result("sra", 8'hC0);
    pulse_tx_done();

    // tx_done while idle has no effect
    pulse_tx_done();
    check("idle_txd_busy", {31'd0, busy}, 32'd0);
    check("idle_txd_start", {31'd0, tx_start}, 32'd0);
    check("idle_txd_a", {24'd0, alu_a}, 32'h80);
    check("idle_txd_tx", {24'd0, tx_data}, 32'hC0);

    // Upper opcode bits ignored: 0xE4 -> AND
    send_byte(8'h0C);
    send_byte(8'h0A);
    send_byte(8'hE4);
    check("and_op", {26'd0, alu_op}, 32'h24);
    check_result("and", 8'h08);
    pulse_tx_done();
    check("and_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/interfaz_alu_uart.md
# interfaz_alu_uart

Sequencing controller that feeds the combinational ALU from a byte-oriented UART receiver and returns the result through the UART transmitter. It collects three received bytes (operand A, operand B, opcode), drives them onto the ALU inputs, captures the ALU result one cycle later, and hands it to the transmitter with a start/done handshake. It sits between the UART RX/TX blocks and the ALU in the top-level.

## Interface
Parameters:
- NB_DATA, 8: operand/result width; equals the UART byte width.
- NB_OP, 6: opcode width; taken from rx_data[NB_OP-1:0].

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_done  in  1  one-cycle pulse: rx_data holds a new byte.
- rx_data  in  NB_DATA  received byte, valid only while rx_done=1.
- tx_done  in  1  one-cycle pulse: transmitter finished the byte.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  out  NB_DATA  registered result byte for the transmitter.
- alu_A  out  NB_DATA  registered operand A to ALU.
- alu_B  out  NB_DATA  registered operand B to ALU.
- alu_Op  out  NB_OP  registered opcode to ALU.
- alu_R  in  NB_DATA  combinational ALU result.
- busy  out  1  high in S_CALC, S_SEND, S_WAIT_TX.
- overrun  out  1  sticky; set when rx_done arrives while busy=1.

## Operation
- States: S_WAIT_A -> S_WAIT_B -> S_WAIT_OP -> S_CALC -> S_SEND -> S_WAIT_TX -> S_WAIT_A.
- S_WAIT_A: on rx_done, alu_A <= rx_data; go S_WAIT_B. Otherwise hold.
- S_WAIT_B: on rx_done, alu_B <= rx_data; go S_WAIT_OP.
- S_WAIT_OP: on rx_done, alu_Op <= rx_data[NB_OP-1:0] (upper bits ignored); go S_CALC.
- S_CALC: one settle cycle; tx_data <= alu_R at end of cycle; go S_SEND unconditionally.
- S_SEND: tx_start=1 for exactly this cycle; go S_WAIT_TX.
- S_WAIT_TX: hold until tx_done; then go S_WAIT_A. tx_done in any other state is ignored.
- rx_done while busy: byte dropped, operand/opcode registers unchanged, overrun <= 1. overrun clears only on reset.
- alu_A/alu_B/alu_Op hold their values after the result is sent until overwritten by the next frame.
- No arithmetic in this block; tx_data is alu_R bit-for-bit (signed interpretation belongs to the ALU).
- Reset (any state, including mid-frame or mid-transmission): state S_WAIT_A; alu_A, alu_B, alu_Op, tx_data = 0; tx_start=0; busy=0; overrun=0. A partially received frame is discarded.

## Timing
- All outputs registered; tx_start is a Moore output of S_SEND.
- Latency: rx_done of opcode byte at edge N -> S_CALC during cycle N+1 -> tx_data valid at edge N+2 -> tx_start high during cycle N+2 to N+3.
- tx_data is stable from capture until the next frame's S_CALC.
- rx_done and tx_done in the same cycle: each handled per its own state rule (only one can apply).
- Back-to-back frames: the first byte of the next frame is accepted on the same edge the FSM returns to S_WAIT_A only if it arrives in the cycle after tx_done.

## Configuration
- OP_CHECK_EN defined: in S_WAIT_OP, opcode byte accepted only if rx_data[NB_OP-1:0] is one of 100000, 100010, 100100, 100101, 100110, 000011, 000010, 100111; an invalid byte is dropped, alu_Op unchanged, FSM stays in S_WAIT_OP.
- OP_CHECK_EN undefined: every opcode byte accepted; invalid codes pass through (ALU returns 0, which is transmitted).

## Test plan
- Reset, send 0x05, 0x03, 0x20 -> alu_A=0x05, alu_B=0x03, alu_Op=100000, tx_data=0x08, single tx_start pulse 2 cycles after third rx_done.
- Send 0x03, 0x05, 0x22 -> tx_data=0xFE; hold tx_done low 50 cycles -> busy stays 1, no second tx_start; pulse tx_done -> S_WAIT_A, busy=0.
- Inject rx_done=0x77 during S_WAIT_TX -> overrun=1, alu_A unchanged; next frame 0x0F, 0xF0, 0x25 -> tx_data=0xFF.
- With OP_CHECK_EN: send 0x01, 0x02, 0x3F, then 0x26 -> 0x3F dropped, no tx_start; after 0x26 tx_data=0x03. Without OP_CHECK_EN: 0x3F -> tx_data=0x00 transmitted.
- Assert rst_n low after A and B received, release, send 0x80, 0x01, 0x03 -> all outputs 0 during reset; result tx_data=0xC0 (SRA by 1).
- Pulse tx_done in S_WAIT_A -> no state change, no output change.
